signed_seq_multiplier: RTL

Sequential signed radix-2 Booth multiplier: WIDTH x WIDTH two's-complement operands give a 2*WIDTH signed product, one Booth step per clock.
It is the inverse-operation companion to the sequential divider and shares its start/done handshake style.
Sits beside the divider in the calculator datapath. Also serves as the verification check q*d + r == D for the divider bench.

---
 rtl/signed_seq_multiplier_pkg.sv | 34 +++
 rtl/signed_seq_multiplier_if.sv | 42 ++++
 rtl/signed_seq_multiplier_booth_step.sv | 42 ++++
 rtl/signed_seq_multiplier.sv | 134 +++++++++++++
 4 files changed

// File: rtl/signed_seq_multiplier_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : signed_seq_multiplier_pkg
//  Description : Shared types and constants for the sequential signed Booth
//                multiplier: FSM state encoding, Booth op codes and decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package signed_seq_multiplier_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        BOOTH_NOP = 2'd0,
        BOOTH_ADD = 2'd1,
        BOOTH_SUB = 2'd2
    } booth_op_t;

    // Radix-2 Booth recoding of the pair {current LSB, previously shifted-out bit}
    function automatic booth_op_t booth_decode(input logic b0, input logic q1);
        case ({b0, q1})
            2'b01:   return BOOTH_ADD;
            2'b10:   return BOOTH_SUB;
            default: return BOOTH_NOP;
        endcase
    endfunction

endpackage : signed_seq_multiplier_pkg
`default_nettype wire

// File: rtl/signed_seq_multiplier_if.sv
`default_nettype none
// ============================================================================
//  Module      : signed_seq_multiplier_if
//  Description : start/done handshake and operand/product bus of the
//                sequential signed multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
interface signed_seq_multiplier_if
    import signed_seq_multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic                 start;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic [2*WIDTH-1:0]   p;
    logic                 done;
    logic                 busy;

    // Requester side
    modport master (
        output start,
        output A,
        output B,
        input  p,
        input  done,
        input  busy
    );

    // Multiplier side
    modport slave (
        input  start,
        input  A,
        input  B,
        output p,
        output done,
        output busy
    );

endinterface : signed_seq_multiplier_if
`default_nettype wire

// File: rtl/signed_seq_multiplier_booth_step.sv
`default_nettype none
// ============================================================================
//  Module      : signed_seq_multiplier_booth_step
//  Description : One combinational radix-2 Booth iteration: conditional
//                add/subtract of the multiplicand into the accumulator
//                followed by an arithmetic right shift of {acc, mq, q_1}.
//  Revision    : 1.0 - initial release
// ============================================================================
module signed_seq_multiplier_booth_step
    import signed_seq_multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  wire logic [WIDTH:0]   i_acc,
    input  wire logic [WIDTH-1:0] i_mq,
    input  wire logic             i_q_1,
    input  wire logic [WIDTH:0]   i_mcand,
    output logic      [WIDTH:0]   o_acc,
    output logic      [WIDTH-1:0] o_mq,
    output logic                  o_q_1
);

    booth_op_t          w_op;
    logic [WIDTH:0]     w_sum;

    assign w_op = booth_decode(i_mq[0], i_q_1);

    // Add/subtract modulo 2^(WIDTH+1), then arithmetic shift right by one
    always_comb begin
        w_sum = i_acc;
        case (w_op)
            BOOTH_ADD: w_sum = i_acc + i_mcand;
            BOOTH_SUB: w_sum = i_acc - i_mcand;
            default:   w_sum = i_acc;
        endcase
        o_acc = {w_sum[WIDTH], w_sum[WIDTH:1]};
        o_mq  = {w_sum[0], i_mq[WIDTH-1:1]};
        o_q_1 = i_mq[0];
    end

endmodule : signed_seq_multiplier_booth_step
`default_nettype wire

// File: rtl/signed_seq_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : signed_seq_multiplier
//  Description : Sequential signed radix-2 Booth multiplier. WIDTH x WIDTH
//                two's-complement operands, 2*WIDTH product, one Booth step
//                per clock, start/done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module signed_seq_multiplier
    import signed_seq_multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    signed_seq_multiplier_if.slave bus
);

    localparam int                CNT_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]  C_CNT_LAST = CNT_W'(WIDTH - 1);

    state_t               r_state;
    state_t               w_state_next;

    logic [WIDTH:0]       r_mcand;
    logic [WIDTH:0]       r_acc;
    logic [WIDTH-1:0]     r_mq;
    logic                 r_q_1;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_p;

    logic [WIDTH:0]       w_acc_next;
    logic [WIDTH-1:0]     w_mq_next;
    logic                 w_q_1_next;

    logic                 w_load;
    logic                 w_step;
    logic                 w_capture;
    logic                 w_done;
    logic                 w_busy;

    signed_seq_multiplier_booth_step #(
        .WIDTH (WIDTH)
    ) u_booth_step (
        .i_acc   (r_acc),
        .i_mq    (r_mq),
        .i_q_1   (r_q_1),
        .i_mcand (r_mcand),
        .o_acc   (w_acc_next),
        .o_mq    (w_mq_next),
        .o_q_1   (w_q_1_next)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and control decode; a start in DONE is accepted like in IDLE
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_capture    = 1'b0;
        w_done       = 1'b0;
        w_busy       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_load       = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                w_step = 1'b1;
                if (r_cnt == C_CNT_LAST) begin
                    w_capture    = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_done = 1'b1;
                if (bus.start) begin
                    w_load       = 1'b1;
                    w_state_next = S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Operand capture, Booth iteration and product latch on entry to DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand <= '0;
            r_acc   <= '0;
            r_mq    <= '0;
            r_q_1   <= 1'b0;
            r_cnt   <= '0;
            r_p     <= '0;
        end else begin
            if (w_load) begin
                r_mcand <= {bus.A[WIDTH-1], bus.A};
                r_acc   <= '0;
                r_mq    <= bus.B;
                r_q_1   <= 1'b0;
                r_cnt   <= '0;
            end else if (w_step) begin
                r_acc   <= w_acc_next;
                r_mq    <= w_mq_next;
                r_q_1   <= w_q_1_next;
                r_cnt   <= r_cnt + 1'b1;
            end
            if (w_capture) begin
                r_p <= {w_acc_next[WIDTH-1:0], w_mq_next};
            end
        end
    end

    assign bus.p    = r_p;
    assign bus.done = w_done;
    assign bus.busy = w_busy;

endmodule : signed_seq_multiplier
`default_nettype wire
